// File: rtl/phy_rx_link_ctrl_if.sv
// Receive-path link interface: deserializer byte stream in, gated payload and link status out.
// master drives the byte stream; slave is the link controller.
interface phy_rx_link_ctrl_if;
  logic        rx_en;
  logic [7:0]  data_in;
  logic        data_in_valid;
  logic        code_err;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        link_up;
  logic [1:0]  state;
  logic        sync_lost;
  logic [15:0] byte_cnt;

  modport master (
    output rx_en, data_in, data_in_valid, code_err,
    input  data_out, valid_out, link_up, state, sync_lost, byte_cnt
  );

  modport slave (
    input  rx_en, data_in, data_in_valid, code_err,
    output data_out, valid_out, link_up, state, sync_lost, byte_cnt
  );
endinterface

// File: rtl/phy_rx_link_ctrl.sv
// PHY receive link-state controller: comma hunt, lock, payload gating and loss-of-sync detection.
// Runs at the byte rate; every output is registered.
module phy_rx_link_ctrl #(
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_MAX  = 3,
  parameter int unsigned WIN_LEN  = 16
) (
  input logic               clk_f,
  input logic               reset,
  phy_rx_link_ctrl_if.slave rx
);

  typedef enum logic [1:0] {
    StDisabled = 2'd0,
    StHunt     = 2'd1,
    StLocking  = 2'd2,
    StActive   = 2'd3
  } state_e;

  localparam logic [3:0] LockCnt = 4'(LOCK_CNT);
  localparam logic [3:0] ErrMax  = 4'(ERR_MAX);
  localparam logic [7:0] WinLast = 8'(WIN_LEN - 1);

  state_e      state_q;
  logic [3:0]  bc_q;
  logic [3:0]  err_q;
  logic [7:0]  win_q;
  logic [15:0] byte_cnt_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        link_q;
  logic        sync_q;

  logic       good_comma;
  logic [3:0] err_nxt;

  assign good_comma = (rx.data_in == COMMA) && !rx.code_err;
  assign err_nxt    = err_q + {3'b000, rx.code_err};

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      state_q    <= StDisabled;
      bc_q       <= '0;
      err_q      <= '0;
      win_q      <= '0;
      byte_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      link_q     <= 1'b0;
      sync_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
      if (rx.data_in_valid) data_q <= rx.data_in;

      // Disable wins everywhere; byte_cnt is kept until the next lock.
      if (!rx.rx_en) begin
        state_q <= StDisabled;
        link_q  <= 1'b0;
        bc_q    <= '0;
        err_q   <= '0;
        win_q   <= '0;
      end else begin
        unique case (state_q)
          StDisabled: state_q <= StHunt;

          StHunt: begin
            if (rx.data_in_valid && good_comma) begin
              state_q <= StLocking;
              bc_q    <= 4'd1;
            end
          end

          StLocking: begin
            if (rx.data_in_valid) begin
              if (good_comma) begin
                if (bc_q + 4'd1 == LockCnt) begin
                  state_q    <= StActive;
                  link_q     <= 1'b1;
                  bc_q       <= '0;
                  byte_cnt_q <= '0;
                  err_q      <= '0;
                  win_q      <= '0;
                end else begin
                  bc_q <= bc_q + 4'd1;
                end
              end else begin
                state_q <= StHunt;
                bc_q    <= '0;
              end
            end
          end

          StActive: begin
            if (rx.data_in_valid) begin
              // Loss of sync outranks the window rollover.
              if (err_nxt >= ErrMax) begin
                state_q <= StHunt;
                link_q  <= 1'b0;
                sync_q  <= 1'b1;
                err_q   <= '0;
                win_q   <= '0;
                bc_q    <= '0;
              end else begin
                if (!rx.code_err && rx.data_in != COMMA) begin
                  valid_q    <= 1'b1;
                  byte_cnt_q <= byte_cnt_q + 16'd1;
                end
                if (win_q == WinLast) begin
                  win_q <= '0;
                  err_q <= '0;
                end else begin
                  win_q <= win_q + 8'd1;
                  err_q <= err_nxt;
                end
              end
            end
          end

          default: state_q <= StDisabled;
        endcase
      end
    end
  end

  assign rx.data_out  = data_q;
  assign rx.valid_out = valid_q;
  assign rx.link_up   = link_q;
  assign rx.state     = state_q;
  assign rx.sync_lost = sync_q;
  assign rx.byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// Bench for phy_rx_link_ctrl: per-cycle reference model feeds a scoreboard queue,
// plus directed checks at the lock, loss-of-sync, rollover and reset points.
module tb_phy_rx_link_ctrl;

  localparam logic [7:0] Comma   = 8'hBC;
  localparam int         LockCnt = 4;
  localparam int         ErrMax  = 3;
  localparam int         WinLen  = 16;

  logic clk_f;
  logic reset;

  phy_rx_link_ctrl_if rx_if ();

  phy_rx_link_ctrl #(
    .COMMA    (Comma),
    .LOCK_CNT (LockCnt),
    .ERR_MAX  (ErrMax),
    .WIN_LEN  (WinLen)
  ) dut (
    .clk_f (clk_f),
    .reset (reset),
    .rx    (rx_if)
  );

  initial clk_f = 1'b0;
  always #5 clk_f = ~clk_f;

  typedef struct packed {
    logic [1:0]  st;
    logic        vld;
    logic [7:0]  dat;
    logic        lnk;
    logic        syn;
    logic [15:0] bcnt;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int sync_seen = 0;

  // Reference model state
  int          m_state, m_bc, m_err, m_win;
  logic [15:0] m_bcnt;
  logic [7:0]  m_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_bc = 0; m_err = 0; m_win = 0;
    m_bcnt  = '0;
    m_dout  = '0;
  endtask

  task automatic model_step(input logic en, input logic v, input logic [7:0] d, input logic e,
                            output exp_t x);
    logic good;
    good  = (d == Comma) && !e;
    x.vld = 1'b0;
    x.syn = 1'b0;
    if (v) m_dout = d;
    if (!en) begin
      m_state = 0; m_bc = 0; m_err = 0; m_win = 0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (v) begin
      if (m_state == 1) begin
        if (good) begin m_state = 2; m_bc = 1; end
      end else if (m_state == 2) begin
        if (!good) begin
          m_state = 1; m_bc = 0;
        end else begin
          m_bc++;
          if (m_bc == LockCnt) begin
            m_state = 3; m_bc = 0; m_bcnt = '0; m_err = 0; m_win = 0;
          end
        end
      end else begin
        if (e) m_err++;
        if (m_err >= ErrMax) begin
          m_state = 1; x.syn = 1'b1; m_err = 0; m_win = 0; m_bc = 0;
        end else begin
          if (!e && d != Comma) begin
            x.vld = 1'b1;
            m_bcnt++;
          end
          if (m_win == WinLen - 1) begin
            m_win = 0; m_err = 0;
          end else begin
            m_win++;
          end
        end
      end
    end
    x.st   = 2'(m_state);
    x.dat  = m_dout;
    x.lnk  = (m_state == 3);
    x.bcnt = m_bcnt;
  endtask

  // One clock: drive, predict, push, then pop and compare after the edge.
  task automatic cyc(input logic en, input logic v, input logic [7:0] d, input logic e);
    exp_t x;
    rx_if.rx_en         = en;
    rx_if.data_in_valid = v;
    rx_if.data_in       = d;
    rx_if.code_err      = e;
    model_step(en, v, d, e, x);
    sb.push_back(x);
    @(posedge clk_f);
    #1;
    x = sb.pop_front();
    chk("state", 32'(rx_if.state), 32'(x.st));
    chk("valid_out", 32'(rx_if.valid_out), 32'(x.vld));
    chk("data_out", 32'(rx_if.data_out), 32'(x.dat));
    chk("link_up", 32'(rx_if.link_up), 32'(x.lnk));
    chk("sync_lost", 32'(rx_if.sync_lost), 32'(x.syn));
    chk("byte_cnt", 32'(rx_if.byte_cnt), 32'(x.bcnt));
    if (rx_if.sync_lost) sync_seen++;
  endtask

  task automatic commas(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, Comma, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    reset               = 1'b1;
    rx_if.rx_en         = 1'b0;
    rx_if.data_in_valid = 1'b0;
    rx_if.data_in       = '0;
    rx_if.code_err      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_f);
    #1;
    reset = 1'b0;
    chk("rst_state", 32'(rx_if.state), 32'd0);
    chk("rst_link", 32'(rx_if.link_up), 32'd0);
    chk("rst_valid", 32'(rx_if.valid_out), 32'd0);
    chk("rst_data", 32'(rx_if.data_out), 32'd0);
    chk("rst_bcnt", 32'(rx_if.byte_cnt), 32'd0);

    // Basic lock and two payload bytes
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("en_to_hunt", 32'(rx_if.state), 32'd1);
    commas(3);
    chk("locking", 32'(rx_if.state), 32'd2);
    commas(1);
    chk("lock_state", 32'(rx_if.state), 32'd3);
    chk("lock_link", 32'(rx_if.link_up), 32'd1);
    cyc(1'b1, 1'b1, 8'h11, 1'b0);
    chk("pay1", 32'({rx_if.valid_out, rx_if.data_out}), 32'h111);
    cyc(1'b1, 1'b1, 8'h22, 1'b0);
    chk("pay2", 32'({rx_if.valid_out, rx_if.data_out}), 32'h122);
    chk("pay_bcnt", 32'(rx_if.byte_cnt), 32'd2);

    // Three code errors inside one window drop the link
    s0 = sync_seen;
    cyc(1'b1, 1'b1, 8'h33, 1'b1);
    cyc(1'b1, 1'b1, 8'h44, 1'b1);
    chk("err2_link", 32'(rx_if.link_up), 32'd1);
    cyc(1'b1, 1'b1, 8'h55, 1'b1);
    chk("los_sync", 32'(rx_if.sync_lost), 32'd1);
    chk("los_state", 32'(rx_if.state), 32'd1);
    chk("los_link", 32'(rx_if.link_up), 32'd0);
    chk("los_valid", 32'(rx_if.valid_out), 32'd0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("los_pulse1", 32'(sync_seen - s0), 32'd1);

    // Aborted lock attempt, then a clean lock
    commas(2);
    cyc(1'b1, 1'b1, 8'h55, 1'b0);
    chk("abort_state", 32'(rx_if.state), 32'd1);
    chk("abort_valid", 32'(rx_if.valid_out), 32'd0);
    commas(3);
    chk("relock_pend", 32'(rx_if.state), 32'd2);
    commas(1);
    chk("relock", 32'(rx_if.state), 32'd3);
    chk("relock_bcnt", 32'(rx_if.byte_cnt), 32'd0);

    // Two errors, window rollover, two more errors: link survives
    s0 = sync_seen;
    cyc(1'b1, 1'b1, 8'hA0, 1'b1);
    cyc(1'b1, 1'b1, 8'hA1, 1'b1);
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b1, 8'(8'h60 + i), 1'b0);
    cyc(1'b1, 1'b1, 8'hA2, 1'b1);
    cyc(1'b1, 1'b1, 8'hA3, 1'b1);
    chk("win_link", 32'(rx_if.link_up), 32'd1);
    chk("win_nosync", 32'(sync_seen - s0), 32'd0);
    chk("win_bcnt", 32'(rx_if.byte_cnt), 32'd14);

    // Strobe toggling: data holds between strobes, commas never valid
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, (i % 3 == 0) ? Comma : 8'(8'hC0 + i), 1'b0);
      cyc(1'b1, 1'b0, 8'hEE, 1'b0);
      chk("gap_valid", 32'(rx_if.valid_out), 32'd0);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : Comma;
      cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), d,
          ($urandom_range(0, 11) == 0));
    end
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    commas(LockCnt + 1);
    cyc(1'b1, 1'b1, 8'h77, 1'b0);
    chk("pre_dis_state", 32'(rx_if.state), 32'd3);

    // Disable mid-ACTIVE, then an async reset pulse between edges
    s0 = sync_seen;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("dis_state", 32'(rx_if.state), 32'd0);
    chk("dis_link", 32'(rx_if.link_up), 32'd0);
    chk("dis_nosync", 32'(sync_seen - s0), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_state", 32'(rx_if.state), 32'd0);
    chk("arst_data", 32'(rx_if.data_out), 32'd0);
    chk("arst_bcnt", 32'(rx_if.byte_cnt), 32'd0);
    chk("arst_link", 32'(rx_if.link_up), 32'd0);
    #2;
    reset = 1'b0;
    model_reset();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("post_rst_hunt", 32'(rx_if.state), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phy_rx_link_ctrl.md
Name: phy_rx_link_ctrl

Overview:
- Link-state controller for the PHY receive path, clocked at the byte rate.
- Consumes the parallel byte stream produced by the serial-to-parallel stage, comma 8'hBC.
- Sequences the receiver through disable, comma hunt, lock and active states, and gates data validity.
- Declares loss of sync on excessive code errors and returns to hunt.

Parameters:
- COMMA, 8'hBC, comma/idle symbol.
- LOCK_CNT, 4, consecutive commas required to lock; range 2..15.
- ERR_MAX, 3, code errors within one window that force loss of sync; range 1..15.
- WIN_LEN, 16, window length in strobed bytes for error counting; range 2..255.

Ports:
- clk_f, input, 1, byte-rate clock.
- reset, input, 1, asynchronous, active-high reset.
- rx_en, input, 1, receiver enable; low forces DISABLED.
- data_in, input, 8, parallel byte from the deserializer.
- data_in_valid, input, 1, byte strobe; a byte is processed only when high.
- code_err, input, 1, decode error flag qualifying data_in.
- data_out, output, 8, registered copy of the last strobed byte.
- valid_out, output, 1, data_out is a good payload byte.
- link_up, output, 1, high while in ACTIVE.
- state, output, 2, 0=DISABLED, 1=HUNT, 2=LOCKING, 3=ACTIVE.
- sync_lost, output, 1, one-cycle pulse on the ACTIVE->HUNT transition.
- byte_cnt, output, 16, count of valid_out bytes since the last lock; wraps.

Behaviour:
- Reset (async, active-high): state=DISABLED, data_out=0, valid_out=0, link_up=0, sync_lost=0, byte_cnt=0; all internal counters 0.
- All outputs are registered. Latency is 1 clk_f from a strobed byte to its data_out/valid_out.
- data_out loads data_in on every strobed cycle and holds otherwise.
- valid_out is 0 on every non-strobed cycle.
- rx_en=0 has top priority in every state: next state=DISABLED, all counters cleared, valid_out=0. No sync_lost pulse.
- Good comma: data_in==COMMA && code_err==0.
- DISABLED: rx_en=1 -> HUNT on the next cycle, independent of data_in_valid.
- HUNT, on a strobed byte:
  - good comma -> LOCKING, bc_cnt=1.
  - anything else -> stay in HUNT.
- LOCKING, on a strobed byte:
  - good comma: bc_cnt+1. When bc_cnt+1==LOCK_CNT -> ACTIVE; clear byte_cnt, err_cnt and win_cnt.
  - any other byte, including a comma with code_err set -> HUNT, bc_cnt=0.
- ACTIVE, on a strobed byte:
  - valid_out=1 only when data_in!=COMMA && code_err==0; byte_cnt increments with each such byte.
  - Commas are idle fill: valid_out=0, no state change.
  - code_err=1: err_cnt+1. win_cnt increments on every strobed byte.
  - If err_cnt+code_err reaches ERR_MAX -> HUNT; pulse sync_lost for 1 cycle; valid_out=0; clear err_cnt, win_cnt and bc_cnt.
  - Otherwise, when win_cnt==WIN_LEN-1, clear both win_cnt and err_cnt.
  - Loss of sync takes precedence over a window rollover in the same cycle.
- Non-strobed cycles: no state or counter change except DISABLED exit and rx_en override.
- byte_cnt wraps 16'hFFFF->0; it holds its value while outside ACTIVE until the next lock.
- Reset asserted mid-frame: immediate clear. After release, the block re-enters HUNT only via DISABLED->HUNT with rx_en=1.

Test Plan:
- Reset, then rx_en=1 with strobed stream BC x4, 0x11, 0x22:
  - state 0->1->2->3; link_up rises after the 4th BC.
  - data_out 0x11 then 0x22, each with valid_out=1; byte_cnt=2.
- BC, BC, 0x55, then BC x4: the lock attempt aborts at 0x55 (state back to 1, no valid_out); lock occurs after the following 4 BCs.
- In ACTIVE, 3 code_err bytes within 16 strobes:
  - sync_lost pulses exactly 1 cycle; state=1, link_up=0, valid_out=0 on the 3rd error.
- In ACTIVE, 2 errors, then 14 clean strobes (window rollover), then 2 more errors: link stays up, no sync_lost.
- In ACTIVE with data_in_valid toggling 1/0: valid_out only on strobed non-BC bytes; data_out holds between strobes.
- Mid-ACTIVE rx_en=0: next cycle state=0, link_up=0, no sync_lost. Then async reset pulse between clock edges: outputs cleared immediately, byte_cnt=0.
